// File: rtl/cache_refill.sv
// cache_refill: line-refill engine feeding the cache/tag SRAM port.
// A request first invalidates the line (tag write of 0). An invalidate-only request
// then finishes. A fill request then fetches four words from memory, writes them into the
// cache SRAM as they arrive, and finally writes the valid tag. A stall watchdog aborts
// a fetch that waits too long for the memory side.
module cache_refill #(
  parameter int TIMEOUT = 64,  // stalled cycles before abort, 0 = never abort
  parameter int TO_W    = 8    // stall counter width, 2**TO_W > TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,             // synchronous, active-low
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_inv_i,
  output logic        mem_avld_o,
  input  logic        mem_ardy_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvld_i,
  output logic        mem_rrdy_o,
  input  logic [31:0] mem_rdata_i,
  output logic        fill_enb_o,
  output logic [8:0]  fill_addr_o,
  output logic [31:0] fill_data_o,
  output logic [3:0]  fill_web_tag_o,
  output logic [3:0]  fill_web_cache_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVAL,
    S_MADDR,
    S_BEAT,
    S_TAG,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [31:0]       addr_q;
  logic              inv_q;
  logic [1:0]        beat_cnt;
  logic [TO_W-1:0]   stall_cnt;

  logic [6:0]        idx;
  logic [22:0]       tag;
  logic [TO_W-1:0]   stall_inc;
  logic              stall_hit;

  assign idx       = addr_q[8:2];
  assign tag       = addr_q[31:9];
  assign stall_inc = stall_cnt + TO_W'(1);
  // The watchdog fires on the stalled cycle that brings the count up to TIMEOUT.
  assign stall_hit = (TIMEOUT != 0) && (stall_inc == TO_W'(TIMEOUT));

  // Request sequencing: invalidate, fetch, write beats, write tag, report.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation results.
    if (!reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      inv_q     <= 1'b0;
      beat_cnt  <= 2'd0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_vld_i) begin
            addr_q <= req_addr_i;
            inv_q  <= req_inv_i;
            state  <= S_INVAL;
          end
        end
        S_INVAL: begin
          stall_cnt <= '0;
          state     <= inv_q ? S_DONE : S_MADDR;
        end
        S_MADDR: begin
          if (mem_ardy_i) begin
            stall_cnt <= '0;
            beat_cnt  <= 2'd0;
            state     <= S_BEAT;
          end else if (stall_hit) begin
            stall_cnt <= '0;
            state     <= S_ERR;
          end else begin
            stall_cnt <= stall_inc;
          end
        end
        S_BEAT: begin
          if (mem_rvld_i) begin
            stall_cnt <= '0;
            beat_cnt  <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) state <= S_TAG;
          end else if (stall_hit) begin
            stall_cnt <= '0;
            state     <= S_ERR;
          end else begin
            stall_cnt <= stall_inc;
          end
        end
        S_TAG:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory address is the word-aligned request address, held for the whole request.
  assign mem_addr_o = addr_q & 32'hFFFF_FFFC;
  assign req_rdy_o  = (state == S_IDLE);

  // Output decode from state; beat writes follow mem_rvld_i in the same cycle.
  always_comb begin
    // NOTE: every output gets an idle default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    mem_avld_o       = 1'b0;
    mem_rrdy_o       = 1'b0;
    fill_enb_o       = 1'b1;
    fill_addr_o      = 9'd0;
    fill_data_o      = 32'd0;
    fill_web_tag_o   = 4'b1111;
    fill_web_cache_o = 4'b1111;
    done_o           = 1'b0;
    err_o            = 1'b0;
    // Outputs stay idle while reset is held low, even before the state register clears.
    if (reset) begin
      unique case (state)
        S_INVAL: begin
          fill_enb_o     = 1'b0;
          fill_addr_o    = {2'b00, idx};
          fill_web_tag_o = 4'b0000;
        end
        S_MADDR: mem_avld_o = 1'b1;
        S_BEAT: begin
          mem_rrdy_o = 1'b1;
          if (mem_rvld_i) begin
            fill_enb_o       = 1'b0;
            fill_addr_o      = {idx, beat_cnt};
            fill_data_o      = mem_rdata_i;
            fill_web_cache_o = 4'b0000;
          end
        end
        S_TAG: begin
          fill_enb_o     = 1'b0;
          fill_addr_o    = {2'b00, idx};
          fill_data_o    = {1'b1, 8'd0, tag};
          fill_web_tag_o = 4'b0000;
        end
        S_DONE:  done_o = 1'b1;
        S_ERR:   err_o  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
